de_stage_ctrl: RTL

DE_STAGE_CTRL -- requirements
Module: de_stage_ctrl

---
 rtl/de_stage_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/de_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : de_stage_ctrl
// Brief    : Decode->execute pipeline register with load-use hazard bubble,
//            branch flush, memory-stall freeze and saturating event counters.
// Revision : 1.0 - initial release
// ============================================================================
module de_stage_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              D_VALID,
    input  logic [31:0]       D_PC,
    input  logic [31:0]       D_RS1,
    input  logic [31:0]       D_RS2,
    input  logic [31:0]       D_IMM,
    input  logic [4:0]        D_ADDR1,
    input  logic [4:0]        D_ADDR2,
    input  logic [4:0]        D_WADDR,
    input  logic [6:0]        D_OP,
    input  logic              D_MEM_READ,
    input  logic              D_MEM_WRITE,
    input  logic              D_REG_WRITE,
    input  logic              E_FLUSH,
    input  logic              MEM_STALL,
    output logic              E_VALID,
    output logic [31:0]       E_PC,
    output logic [31:0]       E_RS1,
    output logic [31:0]       E_RS2,
    output logic [31:0]       E_IMM,
    output logic [4:0]        E_ADDR1,
    output logic [4:0]        E_ADDR2,
    output logic [4:0]        E_WADDR,
    output logic [6:0]        E_OP,
    output logic              E_MEM_READ,
    output logic              E_MEM_WRITE,
    output logic              E_REG_WRITE,
    output logic              PC_EN,
    output logic              FD_EN,
    output logic              FD_FLUSH,
    output logic              LU_STALL,
    output logic [CNT_W-1:0]  LU_CNT,
    output logic [CNT_W-1:0]  FLUSH_CNT
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [0:0] S_RUN     = 1'b0;
    localparam logic [0:0] S_LU_HOLD = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0] state;
    logic [0:0] state_nxt;
    logic       rs1_used;
    logic       rs2_used;
    logic       hit1;
    logic       hit2;
    logic       lu;
    logic       load_bubble;

    assign rs1_used = (D_OP != OP_LUI) && (D_OP != OP_AUIPC) && (D_OP != OP_JAL);
    assign rs2_used = (D_OP == OP_REG) || (D_OP == OP_STORE) || (D_OP == OP_BRANCH);

    assign hit1 = D_VALID && E_VALID && E_MEM_READ && (E_WADDR != 5'd0)
                  && rs1_used && (D_ADDR1 == E_WADDR);
    assign hit2 = D_VALID && E_VALID && E_MEM_READ && (E_WADDR != 5'd0)
                  && rs2_used && (D_ADDR2 == E_WADDR);

    // Store data matching a load is forwarded later, so rs2-only store hits never stall.
    // Only one bubble per load: detection is suppressed while holding.
    assign lu = (state == S_RUN) && (hit1 || (hit2 && (D_OP != OP_STORE)));

    assign load_bubble = E_FLUSH || lu;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: stall freezes, flush wins over load-use, hold lasts one cycle
    always_comb begin
        state_nxt = state;
        if (MEM_STALL) begin
            state_nxt = state;
        end else if (E_FLUSH) begin
            state_nxt = S_RUN;
        end else if (lu) begin
            state_nxt = S_LU_HOLD;
        end else begin
            state_nxt = S_RUN;
        end
    end

    // Pipeline control outputs, combinational from state and inputs
    always_comb begin
        PC_EN    = 1'b1;
        FD_EN    = 1'b1;
        FD_FLUSH = 1'b0;
        LU_STALL = 1'b0;
        if (MEM_STALL) begin
            PC_EN    = 1'b0;
            FD_EN    = 1'b0;
        end else if (E_FLUSH) begin
            FD_FLUSH = 1'b1;
        end else if (lu) begin
            PC_EN    = 1'b0;
            FD_EN    = 1'b0;
            LU_STALL = 1'b1;
        end
    end

    // Execute-stage register: bubble on flush or load-use, hold on stall
    always_ff @(posedge CLK) begin
        if (RST || (!MEM_STALL && load_bubble)) begin
            E_VALID     <= 1'b0;
            E_PC        <= 32'd0;
            E_RS1       <= 32'd0;
            E_RS2       <= 32'd0;
            E_IMM       <= 32'd0;
            E_ADDR1     <= 5'd0;
            E_ADDR2     <= 5'd0;
            E_WADDR     <= 5'd0;
            E_OP        <= 7'd0;
            E_MEM_READ  <= 1'b0;
            E_MEM_WRITE <= 1'b0;
            E_REG_WRITE <= 1'b0;
        end else if (!MEM_STALL) begin
            E_VALID     <= D_VALID;
            E_PC        <= D_PC;
            E_RS1       <= D_RS1;
            E_RS2       <= D_RS2;
            E_IMM       <= D_IMM;
            E_ADDR1     <= D_ADDR1;
            E_ADDR2     <= D_ADDR2;
            E_WADDR     <= D_WADDR;
            E_OP        <= D_OP;
            E_MEM_READ  <= D_MEM_READ;
            E_MEM_WRITE <= D_MEM_WRITE;
            E_REG_WRITE <= D_REG_WRITE;
        end
    end

    // Saturating event counters; a flush masks a simultaneous load-use event
    always_ff @(posedge CLK) begin
        if (RST) begin
            LU_CNT    <= '0;
            FLUSH_CNT <= '0;
        end else if (!MEM_STALL) begin
            if (E_FLUSH) begin
                if (FLUSH_CNT != CNT_MAX) begin
                    FLUSH_CNT <= FLUSH_CNT + 1'b1;
                end
            end else if (lu) begin
                if (LU_CNT != CNT_MAX) begin
                    LU_CNT <= LU_CNT + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
